// File: rtl/tx_frame_sequencer.sv
// Frames payload words for the optical link: preamble, payload MSB-first, transmitter parity,
// then an idle gap. The word is held on tx_word so the parity transmitter can compute over it.
module tx_frame_sequencer #(
  parameter int                DATA_W         = 28,
  parameter int                PRE_W          = 8,
  parameter logic [PRE_W-1:0]  PREAMBLE       = 8'hA5,
  parameter int                CYCLES_PER_BIT = 4,
  parameter int                GAP_BITS       = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] tx_word,
  input  logic              tx_parity,
  output logic              ser_out,
  output logic              bit_strobe,
  output logic              busy,
  output logic              frame_done
);

  localparam int CW       = $clog2(CYCLES_PER_BIT + 1);
  localparam int MAX_BITS = (DATA_W > PRE_W) ? ((DATA_W > GAP_BITS) ? DATA_W : GAP_BITS)
                                             : ((PRE_W > GAP_BITS) ? PRE_W : GAP_BITS);
  localparam int BW       = $clog2(MAX_BITS + 1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_PAR, S_GAP} state_t;

  state_t            state;
  logic [CW-1:0]     cyc_cnt;
  logic [BW-1:0]     bit_idx;
  logic [PRE_W-1:0]  pre_sh;
  logic [DATA_W-1:0] data_sh;
  logic              last_cyc;

  assign last_cyc = (cyc_cnt == CW'(CYCLES_PER_BIT - 1));

  // NOTE: every register here uses <= so all next-state values come from the same
  // pre-edge snapshot; mixing in = would make results depend on statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      s_ready    <= 1'b1;
      tx_word    <= '0;
      ser_out    <= 1'b0;
      bit_strobe <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      cyc_cnt    <= '0;
      bit_idx    <= '0;
      pre_sh     <= '0;
      data_sh    <= '0;
    end else begin
      // NOTE: pulse outputs default low each cycle and are raised only on their event edge.
      bit_strobe <= 1'b0;
      frame_done <= 1'b0;
      if (state != S_IDLE) cyc_cnt <= last_cyc ? '0 : cyc_cnt + CW'(1);

      case (state)
        S_IDLE: begin
          if (s_valid && s_ready) begin
            tx_word    <= s_data;
            data_sh    <= s_data << 1;
            pre_sh     <= PREAMBLE << 1;
            ser_out    <= PREAMBLE[PRE_W-1];
            bit_strobe <= 1'b1;
            s_ready    <= 1'b0;
            busy       <= 1'b1;
            cyc_cnt    <= '0;
            bit_idx    <= '0;
            state      <= S_PRE;
          end
        end
        S_PRE: begin
          if (last_cyc) begin
            bit_strobe <= 1'b1;
            if (bit_idx == BW'(PRE_W - 1)) begin
              bit_idx <= '0;
              ser_out <= tx_word[DATA_W-1];
              state   <= S_DATA;
            end else begin
              bit_idx <= bit_idx + BW'(1);
              ser_out <= pre_sh[PRE_W-1];
              pre_sh  <= pre_sh << 1;
            end
          end
        end
        S_DATA: begin
          if (last_cyc) begin
            bit_strobe <= 1'b1;
            if (bit_idx == BW'(DATA_W - 1)) begin
              bit_idx <= '0;
              ser_out <= tx_parity;
              state   <= S_PAR;
              // With one cycle per bit the parity bit's only cycle is also its last.
              if (CYCLES_PER_BIT == 1) frame_done <= 1'b1;
            end else begin
              bit_idx <= bit_idx + BW'(1);
              ser_out <= data_sh[DATA_W-1];
              data_sh <= data_sh << 1;
            end
          end
        end
        S_PAR: begin
          if (!last_cyc && int'(cyc_cnt) == CYCLES_PER_BIT - 2) frame_done <= 1'b1;
          if (last_cyc) begin
            ser_out <= 1'b0;
            bit_idx <= '0;
            if (GAP_BITS == 0) begin
              s_ready <= 1'b1;
              busy    <= 1'b0;
              state   <= S_IDLE;
            end else begin
              state   <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (last_cyc) begin
            if (int'(bit_idx) == GAP_BITS - 1) begin
              s_ready <= 1'b1;
              busy    <= 1'b0;
              bit_idx <= '0;
              state   <= S_IDLE;
            end else begin
              bit_idx <= bit_idx + BW'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Directed bench for tx_frame_sequencer: default timing instance plus a CPB=1, no-gap instance.
module tb_tx_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [27:0] s_data, s_data1;
  logic        s_valid, s_valid1;
  logic        s_ready, s_ready1;
  logic [27:0] tx_word, tx_word1;
  logic        tx_parity, tx_parity1;
  logic        ser_out, ser_out1;
  logic        bit_strobe, bit_strobe1;
  logic        busy, busy1;
  logic        frame_done, frame_done1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Parity transmitter stand-in.
  assign tx_parity  = ^tx_word;
  assign tx_parity1 = ^tx_word1;

  tx_frame_sequencer dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .tx_word(tx_word), .tx_parity(tx_parity), .ser_out(ser_out), .bit_strobe(bit_strobe),
    .busy(busy), .frame_done(frame_done)
  );

  tx_frame_sequencer #(.CYCLES_PER_BIT(1), .GAP_BITS(0)) dut1 (
    .clk(clk), .rst(rst), .s_data(s_data1), .s_valid(s_valid1), .s_ready(s_ready1),
    .tx_word(tx_word1), .tx_parity(tx_parity1), .ser_out(ser_out1), .bit_strobe(bit_strobe1),
    .busy(busy1), .frame_done(frame_done1)
  );

  typedef struct {
    logic [27:0] data;
    logic        par;   // hand-computed parity of data
    logic        keep;  // hold s_valid high with the next word waiting
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One full default frame (148 cycles) plus 8 gap cycles, checked cycle by cycle.
  task automatic run_frame(input vec_t v, input logic [27:0] next_data);
    logic [36:0] fb;
    fb = {8'hA5, v.data, v.par};
    @(negedge clk);
    check("ready_before_accept", s_ready, 1);
    s_data  = v.data;
    s_valid = 1'b1;
    for (int c = 0; c < 156; c++) begin
      @(negedge clk);
      if (c == 0) begin
        s_valid = v.keep;
        if (v.keep) s_data = next_data;
      end
      if (c < 148) begin
        check("ser_out", ser_out, fb[36 - c/4]);
        check("bit_strobe", bit_strobe, (c % 4) == 0);
      end else begin
        check("gap_ser_out", ser_out, 0);
        check("gap_bit_strobe", bit_strobe, 0);
      end
      check("frame_done", frame_done, c == 147);
      check("s_ready_low", s_ready, 0);
      check("busy_high", busy, 1);
      check("tx_word_held", tx_word, v.data);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [36:0] fb1;
    logic        seen_done, seen_line;

    vecs[0] = '{28'h0000001, 1'b1, 1'b0};
    vecs[1] = '{28'hFFFFFFE, 1'b1, 1'b0};
    vecs[2] = '{28'h94BA8F8, 1'b0, 1'b1};
    vecs[3] = '{28'hAAAAAAA, 1'b0, 1'b0};
    vecs[4] = '{28'h8000000, 1'b1, 1'b0};

    rst = 1'b0; s_data = '0; s_valid = 1'b0; s_data1 = '0; s_valid1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_ready", s_ready, 1);
    check("rst_tx_word", tx_word, 0);
    check("rst_ser_out", ser_out, 0);
    check("rst_bit_strobe", bit_strobe, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_s_ready", s_ready, 1);
    check("idle_ser_out", ser_out, 0);
    check("idle_busy", busy, 0);
    check("idle1_s_ready", s_ready1, 1);

    for (int i = 0; i < 5; i++)
      run_frame(vecs[i], (i < 4) ? vecs[i+1].data : 28'h0);

    // Reset in the middle of the payload.
    @(negedge clk);
    check("ready_before_reset_frame", s_ready, 1);
    s_data = 28'hFFFFFFE; s_valid = 1'b1;
    @(negedge clk) s_valid = 1'b0;
    repeat (60) @(negedge clk);
    check("mid_data_line_high", ser_out, 1);
    check("mid_data_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    check("async_ser_out", ser_out, 0);
    check("async_busy", busy, 0);
    check("async_s_ready", s_ready, 1);
    check("async_tx_word", tx_word, 0);
    @(negedge clk) rst = 1'b1;
    seen_done = 1'b0; seen_line = 1'b0;
    repeat (200) begin
      @(negedge clk);
      seen_done |= frame_done;
      seen_line |= ser_out;
    end
    check("no_frame_done_after_reset", seen_done, 0);
    check("line_idle_after_reset", seen_line, 0);
    check("idle_after_reset_ready", s_ready, 1);
    check("idle_after_reset_busy", busy, 0);

    // One cycle per bit, no gap: 37-cycle frame.
    fb1 = {8'hA5, 28'h94BA8F8, 1'b0};
    @(negedge clk);
    check("cpb1_ready_before", s_ready1, 1);
    s_data1 = 28'h94BA8F8; s_valid1 = 1'b1;
    for (int c = 0; c < 38; c++) begin
      @(negedge clk);
      if (c == 0) s_valid1 = 1'b0;
      if (c < 37) begin
        check("cpb1_ser_out", ser_out1, fb1[36 - c]);
        check("cpb1_bit_strobe", bit_strobe1, 1);
        check("cpb1_busy", busy1, 1);
        check("cpb1_s_ready_low", s_ready1, 0);
        check("cpb1_frame_done", frame_done1, c == 36);
      end else begin
        check("cpb1_s_ready_back", s_ready1, 1);
        check("cpb1_busy_low", busy1, 0);
        check("cpb1_line_idle", ser_out1, 0);
        check("cpb1_done_low", frame_done1, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
